serial_sub: RTL and testbench

Bit-serial subtractor built around the full-subtractor cell: it latches two WIDTH-bit operands and a borrow-in, then computes `a - b - bin` one bit per clock, LSB first, with a registered borrow. It sits behind the combinational full subtractor as the area-minimal sequential user of that cell. It exposes a start/busy/done handshake so a controller can issue subtractions and collect `diff`/`bout`.

---
 rtl/serial_sub.sv | 62 ++++++
 tb/tb_serial_sub.sv | 105 ++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// serial_sub: bit-serial a-b-bin, LSB first, one bit per clock (start/a_in/b_in/bin in; busy/done/diff/bout out)
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh, d_sh, d_nx;
  logic [CW-1:0]    cnt;
  logic             br, d, br_nx;
  always_comb begin
    d     = a_sh[0] ^ b_sh[0] ^ br;
    br_nx = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    d_nx  = (d_sh >> 1) | {d, {(WIDTH-1){1'b0}}};
  end
  assign busy = state == SHIFT;
  assign done = state == DONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      d_sh  <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        a_sh  <= a_in;
        b_sh  <= b_in;
        br    <= bin;
        cnt   <= '0;
        state <= SHIFT;
      end
    end else if (state == SHIFT) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      d_sh <= d_nx;
      br   <= br_nx;
      cnt  <= cnt + CW'(1);
      if (cnt == CW'(WIDTH-1)) begin
        diff  <= d_nx;
        bout  <= br_nx;
        state <= DONE;
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: randomized and directed checks of serial_sub at WIDTH=8 and WIDTH=2 against arithmetic reference
module tb_serial_sub;
  logic       clk = 0, rst_n = 1;
  logic       s8 = 0, bi8 = 0, busy8, done8, bout8;
  logic [7:0] a8 = 0, b8 = 0, d8;
  logic       s2 = 0, bi2 = 0, busy2, done2, bout2;
  logic [1:0] a2 = 0, b2 = 0, d2;
  int         total = 0, bad = 0, nd;
  int         prev[2] = '{0, 0};
  always #5 clk = ~clk;
  serial_sub #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(s8), .a_in(a8), .b_in(b8), .bin(bi8),
    .busy(busy8), .done(done8), .diff(d8), .bout(bout8)
  );
  serial_sub #(.WIDTH(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(s2), .a_in(a2), .b_in(b2), .bin(bi2),
    .busy(busy2), .done(done2), .diff(d2), .bout(bout2)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic drive(input bit w2, input bit st, input int a, input int b, input int bi);
    if (w2) begin
      s2 = st; a2 = 2'(a); b2 = 2'(b); bi2 = 1'(bi);
    end else begin
      s8 = st; a8 = 8'(a); b8 = 8'(b); bi8 = 1'(bi);
    end
  endtask
  task automatic run_op(input bit w2, input int a, input int b, input int bi, input bit poke);
    int w = w2 ? 2 : 8;
    int exp = (a - b - bi) & ((1 << (w + 1)) - 1);
    int nb = 0, n = 0, at = -1;
    logic bz, dn;
    logic [8:0] res;
    @(negedge clk);
    drive(w2, 1, a, b, bi);
    for (int i = 0; i < w + 3; i++) begin
      @(negedge clk);
      bz  = w2 ? busy2 : busy8;
      dn  = w2 ? done2 : done8;
      res = w2 ? 9'({bout2, d2}) : {bout8, d8};
      nb += int'(bz);
      if (dn) begin
        n++;
        at = i;
        check("result", 32'(res), exp);
      end
      if (i < w) check("hold_prev", 32'(res), prev[w2]);
      drive(w2, poke && i == 2, $urandom, $urandom, $urandom);
    end
    check("busy_cycles", nb, w);
    check("done_pulses", n, 1);
    check("done_edge", at, w);
    prev[w2] = exp;
  endtask
  initial begin
    #3 rst_n = 0;
    #1;
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_diff", d8, 0);
    check("rst_bout", bout8, 0);
    @(negedge clk);
    rst_n = 1;
    run_op(0, 'h5A, 'h23, 0, 0);
    run_op(0, 'h00, 'h01, 0, 0);
    run_op(0, 'h10, 'h10, 1, 0);
    run_op(0, 'hFF, 'h00, 1, 0);
    run_op(0, 'h80, 'h01, 0, 1);
    @(negedge clk);
    drive(0, 1, $urandom, $urandom, $urandom);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(0, 0, $urandom, $urandom, $urandom);
    end
    #2 rst_n = 0;
    #1;
    check("midrst_busy", busy8, 0);
    check("midrst_done", done8, 0);
    check("midrst_diff", d8, 0);
    check("midrst_bout", bout8, 0);
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      nd += int'(done8);
    end
    check("midrst_no_done", nd, 0);
    rst_n = 1;
    prev[0] = 0;
    prev[1] = 0;
    run_op(0, 'h03, 'h05, 0, 0);
    for (int i = 0; i < 20; i++)
      run_op(0, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1), 1'($urandom_range(0, 1)));
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int bi = 0; bi < 2; bi++)
          run_op(1, a, b, bi, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
